// File: rtl/wide_adder_seq.sv
// wide_adder_seq: sequential multi-precision adder.
//
// Adds two WIDTH-bit operands (WIDTH = N*WORDS) one N-bit slice per cycle,
// least-significant slice first, through a single n_bit_adder slice with a
// registered carry between slices. Operands are accepted and results are
// returned over valid/ready handshakes.
//
// Optional feature: define WIDE_ADD_OVF_EN to add the `ovf` port, which
// reports two's-complement overflow of a + b + cin.
//
// State   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for operands; in_ready = 1
// RUN     | one slice per cycle, idx = slice being added this cycle
// DONE    | result held stable; out_valid = 1 until out_ready is seen

module n_bit_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    // Plain unsigned N-bit add with carry in/out.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    end

endmodule

module wide_adder_seq #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic               cout
`ifdef WIDE_ADD_OVF_EN
    ,
    output logic               ovf
`endif
);

    localparam int WIDTH = N * WORDS;
    // idx must be at least one bit wide even when WORDS == 1.
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;

    logic [N-1:0]       slice_a;
    logic [N-1:0]       slice_b;
    logic [N-1:0]       slice_sum;
    logic               slice_cout;
    logic               accept;
    logic               last;

    assign accept = in_valid && in_ready;
    assign last   = (idx == IDX_W'(WORDS - 1));

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from registered state only.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Operand capture on accept; these registers carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= a;
            b_reg <= b;
        end
    end

    // Select the operand slices addressed by idx.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx == IDX_W'(w)) begin
                slice_a = a_reg[w*N +: N];
                slice_b = b_reg[w*N +: N];
            end
        end
    end

    n_bit_adder #(.N(N)) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Slice sequencing, carry chaining and result collection.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx   <= '0;
                        carry <= cin;
                        sum   <= '0;
                    end
                end
                RUN: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (idx == IDX_W'(w)) begin
                            sum[w*N +: N] <= slice_sum;
                        end
                    end
                    carry <= slice_cout;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        cout <= slice_cout;
`ifdef WIDE_ADD_OVF_EN
                        // The top slice's sum MSB is the new result sign.
                        ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                (slice_sum[N-1] != a_reg[WIDTH-1]);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_adder_seq.sv
// Testbench for wide_adder_seq (N=4, WORDS=4): directed vectors, backpressure,
// mid-operation reset and random operands against an arithmetic reference.
// Checks ovf too when WIDE_ADD_OVF_EN is defined.

module tb_wide_adder_seq;

    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef WIDE_ADD_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    wide_adder_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef WIDE_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full operation: accept, latency count, result check, optional
    // backpressure for `hold` cycles, then release.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input int hold, input string tag);
        logic [W:0] full;
        logic       ovf_exp;
        int         lat;
        bit         seen;
        full    = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
        ovf_exp = (ta[W-1] == tb_v[W-1]) && (full[W-1] != ta[W-1]);
        @(negedge clk);
        chk(32'(in_ready), 32'd1, {tag, "_in_ready"});
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            lat++;
            @(negedge clk);
        end
        chk(32'(seen), 32'd1, {tag, "_out_valid_seen"});
        chk(32'(lat), 32'(WORDS), {tag, "_latency"});
        chk(32'(sum), 32'(full[W-1:0]), {tag, "_sum"});
        chk(32'(cout), 32'(full[W]), {tag, "_cout"});
`ifdef WIDE_ADD_OVF_EN
        chk(32'(ovf), 32'(ovf_exp), {tag, "_ovf"});
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            chk(32'(out_valid), 32'd1, {tag, "_hold_valid"});
            chk(32'(in_ready), 32'd0, {tag, "_hold_in_ready"});
            chk(32'(sum), 32'(full[W-1:0]), {tag, "_hold_sum"});
            chk(32'(cout), 32'(full[W]), {tag, "_hold_cout"});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk(32'(out_valid), 32'd0, {tag, "_released"});
        chk(32'(in_ready), 32'd1, {tag, "_ready_after"});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk(32'(in_ready), 32'd1, "rst_in_ready");
        chk(32'(out_valid), 32'd0, "rst_out_valid");
        chk(32'(sum), 32'd0, "rst_sum");
        chk(32'(cout), 32'd0, "rst_cout");
        rst = 1'b0;

        run_op(16'hFFFF, 16'h0001, 1'b0, 0, "ffff_p1");
        run_op(16'h1234, 16'h4321, 1'b1, 0, "1234_4321");
        run_op(16'h0FFF, 16'h0001, 1'b0, 0, "0fff_p1");
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, "7fff_p1");
        run_op(16'h8000, 16'h8000, 1'b0, 0, "8000_8000");
        run_op(16'h1111, 16'h2222, 1'b0, 5, "backpressure");

        // Reset after two slices have been processed.
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk(32'(out_valid), 32'd0, "midrst_out_valid");
        chk(32'(sum), 32'd0, "midrst_sum");
        chk(32'(cout), 32'd0, "midrst_cout");
        chk(32'(in_ready), 32'd1, "midrst_in_ready");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk(32'(out_valid), 32'd0, "midrst_no_output");
        end
        run_op(16'h0001, 16'h0001, 1'b0, 0, "after_rst");

        for (int i = 0; i < 25; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
